// File: rtl/alu_issue_scheduler.sv
// Reservation station for the single ALU: holds dispatched uops until both
// source tags are ready (CDB snoop) and issues the oldest eligible one per cycle.
module alu_issue_scheduler #(
  parameter int DEPTH     = 8,
  parameter int PHYS_W    = 6,
  parameter int PAYLOAD_W = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic [PHYS_W-1:0]      disp_src1_tag,
  input  logic                   disp_src1_rdy,
  input  logic [PHYS_W-1:0]      disp_src2_tag,
  input  logic                   disp_src2_rdy,
  input  logic [PAYLOAD_W-1:0]   disp_payload,
  input  logic                   cdb_valid,
  input  logic [PHYS_W-1:0]      cdb_tag,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [PAYLOAD_W-1:0]   iss_payload,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0]     vld, s1_rdy, s2_rdy;
  logic [PHYS_W-1:0]    s1_tag [DEPTH];
  logic [PHYS_W-1:0]    s2_tag [DEPTH];
  logic [PAYLOAD_W-1:0] pl     [DEPTH];
  logic [DEPTH-1:0]     old     [DEPTH];
  logic [DEPTH-1:0]     old_nxt [DEPTH];
  logic [DEPTH-1:0]     elig, sel_oh, alloc_oh;
  logic                 disp_fire, iss_fire, cap1, cap2;

  assign elig       = vld & s1_rdy & s2_rdy;
  assign disp_ready = (occupancy < FULL);
  assign iss_valid  = |elig;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign iss_fire   = iss_valid && iss_ready && !flush;
  assign cap1 = disp_src1_rdy || (disp_src1_tag == '0) || (cdb_valid && (cdb_tag == disp_src1_tag));
  assign cap2 = disp_src2_rdy || (disp_src2_tag == '0) || (cdb_valid && (cdb_tag == disp_src2_tag));

  // Select: an eligible entry wins unless some older entry is also eligible.
  always_comb begin
    sel_oh = elig;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (elig[j] && old[j][i]) sel_oh[i] = 1'b0;
  end

  always_comb begin
    iss_payload = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sel_oh[i]) iss_payload = pl[i];
  end

  // Lowest-index free slot: scan downward so the last hit is the lowest.
  always_comb begin
    alloc_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!vld[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
      end
  end

  // A new entry is younger than every survivor; the issued entry drops out of both axes.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++) begin
        old_nxt[i][j] = old[i][j];
        if (iss_fire && (sel_oh[i] || sel_oh[j])) old_nxt[i][j] = 1'b0;
        if (disp_fire && alloc_oh[j]) old_nxt[i][j] = vld[i] && !(iss_fire && sel_oh[i]);
        if (disp_fire && alloc_oh[i]) old_nxt[i][j] = 1'b0;
      end
  end

  // Control state: entry valids, age matrix, occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld       <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) old[i] <= '0;
    end else begin
      vld       <= (vld & ~(iss_fire ? sel_oh : '0)) | (disp_fire ? alloc_oh : '0);
      occupancy <= occupancy + CW'(disp_fire) - CW'(iss_fire);
      for (int i = 0; i < DEPTH; i++) old[i] <= old_nxt[i];
    end
  end

  // Entry data: capture on allocation, otherwise snoop the CDB for wakeup
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (disp_fire && alloc_oh[i]) begin
        s1_tag[i] <= disp_src1_tag;
        s2_tag[i] <= disp_src2_tag;
        s1_rdy[i] <= cap1;
        s2_rdy[i] <= cap2;
        pl[i]     <= disp_payload;
      end else if (cdb_valid) begin
        if (cdb_tag == s1_tag[i]) s1_rdy[i] <= 1'b1;
        if (cdb_tag == s2_tag[i]) s2_rdy[i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Bench for alu_issue_scheduler: directed scenarios plus random traffic, checked
// every cycle against a dispatch-ordered queue model of the reservation station.
module tb_alu_issue_scheduler;
  localparam int DEPTH = 8;
  localparam int PHYS_W = 6;
  localparam int PAYLOAD_W = 128;

  logic                 clk = 1'b0;
  logic                 rst, flush, disp_valid, disp_ready;
  logic [PHYS_W-1:0]    disp_src1_tag, disp_src2_tag, cdb_tag;
  logic                 disp_src1_rdy, disp_src2_rdy, cdb_valid;
  logic [PAYLOAD_W-1:0] disp_payload, iss_payload;
  logic                 iss_valid, iss_ready;
  logic [3:0]           occupancy;

  alu_issue_scheduler #(.DEPTH(DEPTH), .PHYS_W(PHYS_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
    .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy),
    .disp_payload(disp_payload),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                 r1, r2;
    logic [PHYS_W-1:0]    t1, t2;
    logic [PAYLOAD_W-1:0] pl;
  } ent_t;

  ent_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [PAYLOAD_W-1:0] got, input logic [PAYLOAD_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int oldest_ready();
    for (int i = 0; i < q.size(); i++)
      if (q[i].r1 && q[i].r2) return i;
    return -1;
  endfunction

  function automatic logic [PAYLOAD_W-1:0] rnd_pl();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_edge(input int s);
    bit do_iss, do_disp;
    ent_t e;
    if (rst || flush) begin
      q.delete();
      return;
    end
    do_iss  = (s >= 0) && iss_ready;
    do_disp = disp_valid && (q.size() < DEPTH);
    if (cdb_valid)
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        if (e.t1 == cdb_tag) e.r1 = 1'b1;
        if (e.t2 == cdb_tag) e.r2 = 1'b1;
        q[i] = e;
      end
    if (do_iss) q.delete(s);
    if (do_disp) begin
      e.t1 = disp_src1_tag;
      e.t2 = disp_src2_tag;
      e.r1 = disp_src1_rdy || (disp_src1_tag == 0) || (cdb_valid && cdb_tag == disp_src1_tag);
      e.r2 = disp_src2_rdy || (disp_src2_tag == 0) || (cdb_valid && cdb_tag == disp_src2_tag);
      e.pl = disp_payload;
      q.push_back(e);
    end
  endtask

  task automatic step();
    int s;
    s = oldest_ready();
    chk("disp_ready", PAYLOAD_W'(disp_ready), PAYLOAD_W'(q.size() < DEPTH));
    chk("iss_valid", PAYLOAD_W'(iss_valid), PAYLOAD_W'(s >= 0));
    chk("occupancy", PAYLOAD_W'(occupancy), PAYLOAD_W'(q.size()));
    if (s >= 0) chk("iss_payload", iss_payload, q[s].pl);
    @(posedge clk);
    model_edge(s);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0; cdb_tag = '0;
    disp_src1_tag = '0; disp_src2_tag = '0; disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
    disp_payload = '0;
  endtask

  task automatic disp(input int t1, input bit r1, input int t2, input bit r2);
    disp_valid = 1'b1;
    disp_src1_tag = PHYS_W'(t1); disp_src1_rdy = r1;
    disp_src2_tag = PHYS_W'(t2); disp_src2_rdy = r2;
    disp_payload = rnd_pl();
  endtask

  initial begin
    idle();
    iss_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    rst = 1'b0;
    step();

    // in-order issue of three ready uops
    iss_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin disp(0, 1, 0, 1); step(); end
    idle(); repeat (3) step();

    // younger ready uop bypasses a waiting one; CDB wakes the older one
    disp(5, 0, 0, 1); step();
    disp(0, 1, 0, 1); step();
    idle(); step();
    cdb_valid = 1'b1; cdb_tag = 6'd5; step();
    idle(); repeat (3) step();

    // same-cycle CDB bypass at dispatch
    disp(0, 1, 9, 0); cdb_valid = 1'b1; cdb_tag = 6'd9; step();
    idle(); repeat (2) step();

    // fill to full, ninth dispatch ignored, then free one slot
    iss_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin disp(10 + i, 0, 0, 1); step(); end
    disp(0, 1, 0, 1); step();
    idle(); cdb_valid = 1'b1; cdb_tag = 6'd10; step();
    idle(); iss_ready = 1'b1; step();
    iss_ready = 1'b0; repeat (2) step();
    flush = 1'b1; step();
    idle(); step();

    // stall with four ready entries, then drain
    for (int i = 0; i < 4; i++) begin disp(0, 1, 0, 1); step(); end
    idle(); repeat (3) step();
    iss_ready = 1'b1; repeat (5) step();

    // flush with a concurrent dispatch, then reset mid-fill
    iss_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin disp(20 + i, 0, 0, 1); step(); end
    disp(0, 1, 0, 1); flush = 1'b1; step();
    idle(); step();
    for (int i = 0; i < 3; i++) begin disp(0, 1, 0, 1); step(); end
    disp(0, 1, 0, 1); rst = 1'b1; flush = 1'b1; step();
    idle(); step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(0, 99) < 60)
        disp($urandom_range(0, 7), $urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 3) == 0);
      cdb_valid = ($urandom_range(0, 99) < 40);
      cdb_tag   = PHYS_W'($urandom_range(0, 7));
      iss_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 199) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      step();
    end
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
